inc4_count_reg: RTL



---
 rtl/inc4_count_reg_if.sv | 30 +++
 rtl/inc4_count_reg.sv | 87 ++++++++
 2 files changed

// File: rtl/inc4_count_reg_if.sv
// Control/status bundle for the inc4_count_reg counter stage.
// Build option: CNT_LOAD_EN adds the parallel-load pair load/din.
interface inc4_count_reg_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             en;
   logic             oneshot;
`ifdef CNT_LOAD_EN
   logic             load;
   logic [WIDTH-1:0] din;
`endif
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;
   logic             done;

`ifdef CNT_LOAD_EN
   modport master (output start, stop, en, oneshot, load, din,
                   input  q, tc, busy, done);
   modport slave  (input  start, stop, en, oneshot, load, din,
                   output q, tc, busy, done);
`else
   modport master (output start, stop, en, oneshot,
                   input  q, tc, busy, done);
   modport slave  (input  start, stop, en, oneshot,
                   output q, tc, busy, done);
`endif
endinterface

// File: rtl/inc4_count_reg.sv
// Registered modulo-MOD counter built on a half-adder ripple incrementer,
// gated by an IDLE/RUN/DONE run-control FSM with one-shot or free-run wrap.
// Build option: CNT_LOAD_EN adds a saturating parallel load (load/din).
module inc4_count_reg #(
   parameter int WIDTH = 4,
   parameter int MOD   = 16
) (
   input  logic              clk,
   input  logic              rst,
   inc4_count_reg_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_q, w_q_nxt, w_inc, w_c;
   logic             r_tc, r_busy, r_done;
   logic             w_step, w_wrap, w_load;

`ifdef CNT_LOAD_EN
   logic [WIDTH-1:0] w_din_sat;
   assign w_load    = bus.load;
   // Out-of-range load values clamp to the last legal count.
   assign w_din_sat = ({1'b0, bus.din} >= (WIDTH+1)'(MOD)) ? LAST : bus.din;
`else
   assign w_load    = 1'b0;
`endif

   // Half-adder ripple incrementer: carry-in fixed at 1, final carry-out
   // is not generated since wrap is decided by the MOD compare instead.
   assign w_c[0] = 1'b1;
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ha
      assign w_inc[gi] = r_q[gi] ^ w_c[gi];
      if (gi < WIDTH - 1) begin : g_cy
         assign w_c[gi+1] = r_q[gi] & w_c[gi];
      end
   end

   // Next state and next count; stop beats start and beats the DONE transition.
   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_step      = (r_state == S_RUN) && bus.en;
      w_wrap      = w_step && (r_q == LAST);
      case (r_state)
         S_IDLE: if (bus.start && !bus.stop) w_state_nxt = S_RUN;
         S_RUN: begin
            if (bus.stop)                               w_state_nxt = S_IDLE;
            else if (w_wrap && !w_load && bus.oneshot)  w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (bus.start && !bus.stop) begin
               w_state_nxt = S_RUN;
               w_q_nxt     = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_step) w_q_nxt = w_wrap ? '0 : w_inc;
`ifdef CNT_LOAD_EN
      if (w_load) w_q_nxt = w_din_sat;
`endif
   end

   // State, count and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_tc    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_tc    <= w_wrap && !w_load;
         r_busy  <= (w_state_nxt == S_RUN);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   assign bus.q    = r_q;
   assign bus.tc   = r_tc;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
endmodule
